// File: rtl/alu_arbiter_if.sv
// Bundles the two requester channels, the two response channels and the shared-ALU hookup.
// Latency: none; wires only.
// Backpressure: valid/ready on each requester and response channel.
interface alu_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]       req0_ctrl, req1_ctrl;

  logic             rsp0_valid, rsp1_valid;
  logic             rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0] rsp0_data, rsp1_data;
  logic             rsp0_zero, rsp0_ovf, rsp0_carry;
  logic             rsp1_zero, rsp1_ovf, rsp1_carry;

  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic [3:0]       alu_ctrl;
  logic             alu_zero, alu_ovf, alu_carry;

  // Arbiter side
  modport slave (
    input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_ctrl, req1_ctrl,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    output rsp0_zero, rsp0_ovf, rsp0_carry, rsp1_zero, rsp1_ovf, rsp1_carry,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_out, alu_zero, alu_ovf, alu_carry
  );

  // Requester / ALU environment side
  modport master (
    output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b, req0_ctrl, req1_ctrl,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data,
    input  rsp0_zero, rsp0_ovf, rsp0_carry, rsp1_zero, rsp1_ovf, rsp1_carry,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_out, alu_zero, alu_ovf, alu_carry
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU, one op in flight.
// Latency: accept in cycle T, response valid in T+2; issue interval at least 3 cycles.
// Backpressure: response held until its ready; no new request accepted meanwhile.
module alu_arbiter #(
  parameter int WIDTH     = 32,
  parameter int PRIO_INIT = 0
) (
  input logic          clk,
  input logic          rst,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  // last_grant starts as the "other" requester so the first tie goes to PRIO_INIT
  localparam logic LAST_INIT = (PRIO_INIT == 0) ? 1'b1 : 1'b0;

  state_t                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   idx_q, idx_d;
  logic [WIDTH-1:0]       a_q, a_d, b_q, b_d;
  logic [3:0]             ctrl_q, ctrl_d;
  logic [1:0][WIDTH-1:0]  data_q, data_d;
  logic [1:0]             zero_q, zero_d, ovf_q, ovf_d, carry_q, carry_d;

  logic any_vld;
  logic gnt_idx;
  logic add_cls;
  logic rsp_take;

  // Arbitration: a tie goes to whoever was not granted last, a lone requester always wins
  always_comb begin
    any_vld = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      gnt_idx = ~last_q;
    end else begin
      gnt_idx = bus.req1_valid;
    end
    rsp_take = idx_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  // Carry only means something for add-like codes; logic/compare ops mask it
  always_comb begin
    case (ctrl_q)
      4'b1111, 4'b1100, 4'b0111, 4'b0110, 4'b0000, 4'b0001: add_cls = 1'b0;
      default:                                              add_cls = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_take) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic; reset forces every handshake and result output low
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    if (!rst && state_q == IDLE && any_vld) begin
      bus.req0_ready = ~gnt_idx;
      bus.req1_ready = gnt_idx;
    end
    bus.rsp0_valid = !rst && state_q == RESP && !idx_q;
    bus.rsp1_valid = !rst && state_q == RESP &&  idx_q;
    bus.rsp0_data  = rst ? '0   : data_q[0];
    bus.rsp1_data  = rst ? '0   : data_q[1];
    bus.rsp0_zero  = rst ? 1'b0 : zero_q[0];
    bus.rsp1_zero  = rst ? 1'b0 : zero_q[1];
    bus.rsp0_ovf   = rst ? 1'b0 : ovf_q[0];
    bus.rsp1_ovf   = rst ? 1'b0 : ovf_q[1];
    bus.rsp0_carry = rst ? 1'b0 : carry_q[0];
    bus.rsp1_carry = rst ? 1'b0 : carry_q[1];
    bus.alu_a      = a_q;
    bus.alu_b      = b_q;
    bus.alu_ctrl   = ctrl_q;
  end

  // Datapath next state: latch the winner's operands on grant, capture the ALU in EXEC
  always_comb begin
    last_d  = last_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    carry_d = carry_q;
    if (state_q == IDLE && any_vld) begin
      idx_d  = gnt_idx;
      last_d = gnt_idx;
      a_d    = gnt_idx ? bus.req1_a    : bus.req0_a;
      b_d    = gnt_idx ? bus.req1_b    : bus.req0_b;
      ctrl_d = gnt_idx ? bus.req1_ctrl : bus.req0_ctrl;
    end
    if (state_q == EXEC) begin
      data_d[idx_q]  = bus.alu_out;
      zero_d[idx_q]  = bus.alu_zero;
      ovf_d[idx_q]   = bus.alu_ovf & (add_cls | (ctrl_q == 4'b0110));
      carry_d[idx_q] = bus.alu_carry & add_cls;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= LAST_INIT;
      idx_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 4'b0000;
      data_q  <= '0;
      zero_q  <= '0;
      ovf_q   <= '0;
      carry_q <= '0;
    end else begin
      last_q  <= last_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      carry_q <= carry_d;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, multi-cycle corner sequences, random scoreboard.
// Latency: n/a.
// Backpressure: response ready driven low/random to exercise hold behaviour.
module tb_alu_arbiter;

  localparam int NR = 30;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_arbiter_if #(.WIDTH(32)) bus ();

  alu_arbiter #(.WIDTH(32), .PRIO_INIT(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Drive side
  logic [1:0]  rv;
  logic [31:0] ra [2];
  logic [31:0] rb [2];
  logic [3:0]  rc [2];
  logic [1:0]  sr;

  assign bus.req0_valid = rv[0];
  assign bus.req1_valid = rv[1];
  assign bus.req0_a = ra[0];
  assign bus.req0_b = rb[0];
  assign bus.req0_ctrl = rc[0];
  assign bus.req1_a = ra[1];
  assign bus.req1_b = rb[1];
  assign bus.req1_ctrl = rc[1];
  assign bus.rsp0_ready = sr[0];
  assign bus.rsp1_ready = sr[1];

  // Observe side
  logic [1:0]  rdy, vld;
  logic [31:0] rd [2];
  logic [2:0]  rf [2];
  assign rdy   = {bus.req1_ready, bus.req0_ready};
  assign vld   = {bus.rsp1_valid, bus.rsp0_valid};
  assign rd[0] = bus.rsp0_data;
  assign rd[1] = bus.rsp1_data;
  assign rf[0] = {bus.rsp0_zero, bus.rsp0_ovf, bus.rsp0_carry};
  assign rf[1] = {bus.rsp1_zero, bus.rsp1_ovf, bus.rsp1_carry};

  // Environment ALU: one adder (subtracting for 0110/0111) always reports raw flags,
  // so the arbiter's masking is visible.
  logic        alu_sub;
  logic [31:0] alu_bb;
  logic [32:0] alu_sum;
  always_comb begin
    alu_sub = (bus.alu_ctrl == 4'b0110) || (bus.alu_ctrl == 4'b0111);
    alu_bb  = alu_sub ? ~bus.alu_b : bus.alu_b;
    alu_sum = {1'b0, bus.alu_a} + {1'b0, alu_bb} + {32'd0, alu_sub};
    case (bus.alu_ctrl)
      4'b0000: bus.alu_out = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_out = bus.alu_a | bus.alu_b;
      4'b0111: bus.alu_out = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'b1100: bus.alu_out = ~(bus.alu_a | bus.alu_b);
      4'b1111: bus.alu_out = bus.alu_a ^ bus.alu_b;
      default: bus.alu_out = alu_sum[31:0];
    endcase
    bus.alu_zero  = (bus.alu_out == 32'd0);
    bus.alu_carry = alu_sum[32];
    bus.alu_ovf   = (bus.alu_a[31] == alu_bb[31]) && (alu_sum[31] != bus.alu_a[31]);
  end

  // Reference result: plain wide arithmetic, flags masked by op class
  function automatic void expect_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                                    output logic [31:0] d, output logic z, output logic o,
                                    output logic cy);
    longint sa, sb, r;
    longint unsigned ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    o  = 1'b0;
    cy = 1'b0;
    case (c)
      4'b0000: d = a & b;
      4'b0001: d = a | b;
      4'b1100: d = ~(a | b);
      4'b1111: d = a ^ b;
      4'b0111: d = (sa < sb) ? 32'd1 : 32'd0;
      4'b0110: begin
        d = a - b;
        r = sa - sb;
        o = (r != longint'($signed(d)));
      end
      default: begin
        d  = a + b;
        r  = sa + sb;
        o  = (r != longint'($signed(d)));
        cy = ((ua + ub) >> 32) != 0;
      end
    endcase
    z = (d == 32'd0);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=%h expected=%h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic wait_rdy(input int idx, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rdy[idx]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", {31'd0, rdy[idx]}, 32'd1);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a, b;
    logic [3:0]  c;
    logic [31:0] d;
    logic        z, o, cy;
  } vec_t;

  typedef struct {
    logic [31:0] a, b;
    logic [3:0]  c;
  } op_t;

  vec_t vecs [11];
  op_t  ops [2][NR];
  logic [3:0] clist [8];

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ok;
    int          gi [$];
    int          gc [$];
    int          ptr [2];
    bit          pres [2];
    bit          outst, exp_acc;
    int          out_n, acc_cyc, free_cyc, last_m, now, w;
    logic [31:0] ed;
    logic        ez, eo, ec;

    vecs[0]  = '{0, 32'd5,          32'd7,          4'b0010, 32'd12,         1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1, 32'h7FFF_FFFF,  32'd1,          4'b0010, 32'h8000_0000,  1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1, 32'h7FFF_FFFF,  32'd1,          4'b0000, 32'd1,          1'b0, 1'b0, 1'b0};
    vecs[3]  = '{0, 32'hFFFF_FFFF,  32'd1,          4'b0111, 32'd1,          1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1, 32'd3,          32'd3,          4'b0110, 32'd0,          1'b1, 1'b0, 1'b0};
    vecs[5]  = '{0, 32'hFFFF_FFFF,  32'd2,          4'b0010, 32'd1,          1'b0, 1'b0, 1'b1};
    vecs[6]  = '{0, 32'h8000_0000,  32'd1,          4'b0110, 32'h7FFF_FFFF,  1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1, 32'h0000_00F0,  32'h0000_000F,  4'b0001, 32'h0000_00FF,  1'b0, 1'b0, 1'b0};
    vecs[8]  = '{0, 32'd0,          32'd0,          4'b1100, 32'hFFFF_FFFF,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1, 32'h1234_5678,  32'h1234_5678,  4'b1111, 32'd0,          1'b1, 1'b0, 1'b0};
    vecs[10] = '{0, 32'h8000_0000,  32'h8000_0000,  4'b0011, 32'd0,          1'b1, 1'b1, 1'b1};
    clist = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1111, 4'b0011};

    // Reset with requests pending: everything must stay quiet
    rst = 1'b1;
    rv  = 2'b11;
    ra[0] = 32'hDEAD_BEEF; rb[0] = 32'h1; rc[0] = 4'b0010;
    ra[1] = 32'hCAFE_F00D; rb[1] = 32'h2; rc[1] = 4'b0010;
    sr  = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {30'd0, rdy}, 32'd0);
    chk("rst_rsp_valid", {30'd0, vld}, 32'd0);
    chk("rst_rsp0_data", rd[0], 32'd0);
    chk("rst_rsp1_data", rd[1], 32'd0);
    chk("rst_flags", {26'd0, rf[1], rf[0]}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    rv  = 2'b00;
    @(negedge clk);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);

    // Continuous tie: grants alternate 0,1,0,1 every 3 cycles starting with PRIO_INIT
    @(posedge clk); #1;
    ra[0] = 32'd5; rb[0] = 32'd7; rc[0] = 4'b0010;
    ra[1] = 32'd3; rb[1] = 32'd3; rc[1] = 4'b0110;
    rv = 2'b11;
    sr = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (rdy != 2'b00) begin
        chk("tie_onehot", {31'd0, (rdy == 2'b01) || (rdy == 2'b10)}, 32'd1);
        gi.push_back(int'(rdy[1]));
        gc.push_back(k);
      end
      if (vld[1]) begin
        chk("tie_rsp1_data", rd[1], 32'd0);
        chk("tie_rsp1_zero", {31'd0, rf[1][2]}, 32'd1);
      end
    end
    @(posedge clk); #1;
    rv = 2'b00;
    chk("tie_count", gi.size(), 32'd4);
    for (int j = 0; j < gi.size() && j < 4; j++) begin
      chk("tie_idx", gi[j], j % 2);
      chk("tie_cycle", gc[j], 3 * j);
    end

    // Directed vector table: single requester, fixed latency, masked flags
    for (int i = 0; i < 11; i++) begin
      vec_t v;
      v = vecs[i];
      @(posedge clk); #1;
      rv = 2'b00;
      ra[v.idx] = v.a; rb[v.idx] = v.b; rc[v.idx] = v.c;
      rv[v.idx] = 1'b1;
      sr = 2'b11;
      wait_rdy(v.idx, ok);
      if (ok) begin
        chk("tbl_other_ready", {31'd0, rdy[1 - v.idx]}, 32'd0);
        @(posedge clk); #1;
        rv = 2'b00;
        @(negedge clk);
        chk("tbl_no_early_rsp", {30'd0, vld}, 32'd0);
        chk("tbl_alu_a", bus.alu_a, v.a);
        @(negedge clk);
        chk("tbl_rsp_valid", {30'd0, vld}, 32'(2'b01 << v.idx));
        chk("tbl_data", rd[v.idx], v.d);
        chk("tbl_flags_zoc", {29'd0, rf[v.idx]}, {29'd0, v.z, v.o, v.cy});
      end
    end

    // Response backpressure: held result, other requester blocked until consumed
    @(posedge clk); #1;
    ra[0] = 32'd5; rb[0] = 32'd7; rc[0] = 4'b0010;
    rv = 2'b01;
    sr = 2'b10;
    wait_rdy(0, ok);
    @(posedge clk); #1;
    ra[1] = 32'd1; rb[1] = 32'd1; rc[1] = 4'b0010;
    rv = 2'b10;
    @(negedge clk);
    chk("bp_req1_ready_exec", {31'd0, rdy[1]}, 32'd0);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("bp_rsp0_valid", {31'd0, vld[0]}, 32'd1);
      chk("bp_rsp0_data", rd[0], 32'd12);
      chk("bp_req1_ready", {31'd0, rdy[1]}, 32'd0);
    end
    @(posedge clk); #1;
    sr = 2'b11;
    @(negedge clk);
    chk("bp_consume_valid", {31'd0, vld[0]}, 32'd1);
    chk("bp_consume_req1_ready", {31'd0, rdy[1]}, 32'd0);
    @(negedge clk);
    chk("bp_after_valid", {31'd0, vld[0]}, 32'd0);
    chk("bp_req1_granted", {30'd0, rdy}, 32'd2);
    @(posedge clk); #1;
    rv = 2'b00;
    @(negedge clk);
    @(negedge clk);
    chk("bp_rsp1_valid", {30'd0, vld}, 32'd2);
    chk("bp_rsp1_data", rd[1], 32'd2);

    // Reset while an operation is in flight
    @(negedge clk);
    @(posedge clk); #1;
    ra[0] = 32'd9; rb[0] = 32'd9; rc[0] = 4'b0010;
    ra[1] = 32'd4; rb[1] = 32'd4; rc[1] = 4'b0010;
    rv = 2'b01;
    sr = 2'b11;
    wait_rdy(0, ok);
    @(posedge clk); #1;
    rv  = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {30'd0, rdy}, 32'd0);
    chk("mid_rst_valid", {30'd0, vld}, 32'd0);
    chk("mid_rst_data", rd[0] | rd[1], 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", {30'd0, vld}, 32'd0);
    chk("post_rst_data", rd[0] | rd[1], 32'd0);
    chk("post_rst_flags", {26'd0, rf[1], rf[0]}, 32'd0);
    chk("post_rst_alu_ab", bus.alu_a | bus.alu_b, 32'd0);
    chk("post_rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", {30'd0, vld}, 32'd0);
    end
    @(posedge clk); #1;
    rv = 2'b11;
    @(negedge clk);
    chk("post_rst_tie_prio", {30'd0, rdy}, 32'd1);
    @(posedge clk); #1;
    rv = 2'b00;
    repeat (3) @(negedge clk);

    // Random traffic against the transaction-level scoreboard
    for (int n = 0; n < 2; n++) begin
      ptr[n]  = 0;
      pres[n] = 1'b0;
      for (int j = 0; j < NR; j++) begin
        ops[n][j].a = rnd_val();
        ops[n][j].b = rnd_val();
        ops[n][j].c = clist[$urandom_range(0, 7)];
      end
    end
    outst    = 1'b0;
    out_n    = 0;
    acc_cyc  = 0;
    free_cyc = 0;
    last_m   = 0;
    ed = '0; ez = 1'b0; eo = 1'b0; ec = 1'b0;
    for (int t = 0; t < 4000 && (ptr[0] < NR || ptr[1] < NR || outst); t++) begin
      @(posedge clk); #1;
      for (int n = 0; n < 2; n++) begin
        if (ptr[n] < NR) begin
          if (!pres[n] && $urandom_range(0, 1) == 1) pres[n] = 1'b1;
        end else begin
          pres[n] = 1'b0;
        end
        rv[n] = pres[n];
        if (pres[n]) begin
          ra[n] = ops[n][ptr[n]].a;
          rb[n] = ops[n][ptr[n]].b;
          rc[n] = ops[n][ptr[n]].c;
        end
      end
      sr = 2'($urandom_range(0, 3));
      @(negedge clk);
      now = cyc;
      if (outst) begin
        if (now == acc_cyc + 2) chk("rnd_latency", {31'd0, vld[out_n]}, 32'd1);
        if (vld != 2'b00) begin
          chk("rnd_rsp_index", {30'd0, vld}, 32'(2'b01 << out_n));
          chk("rnd_not_early", {31'd0, now >= acc_cyc + 2}, 32'd1);
        end
        if (vld[out_n]) begin
          chk("rnd_data", rd[out_n], ed);
          chk("rnd_flags_zoc", {29'd0, rf[out_n]}, {29'd0, ez, eo, ec});
          if (sr[out_n]) begin
            outst    = 1'b0;
            free_cyc = now + 1;
          end
        end
      end else if (vld != 2'b00) begin
        chk("rnd_spurious_rsp", {30'd0, vld}, 32'd0);
      end
      exp_acc = !outst && now >= free_cyc && rv != 2'b00 && !(outst == 1'b0 && now < free_cyc);
      if (rdy != 2'b00 || exp_acc) begin
        chk("rnd_accept", {31'd0, rdy != 2'b00}, {31'd0, exp_acc});
        w = (rv == 2'b11) ? 1 - last_m : int'(rv[1]);
        if (exp_acc) begin
          chk("rnd_winner", {30'd0, rdy}, 32'(2'b01 << w));
          if (rdy == 2'(2'b01 << w)) begin
            expect_op(ops[w][ptr[w]].a, ops[w][ptr[w]].b, ops[w][ptr[w]].c, ed, ez, eo, ec);
            ptr[w]++;
            pres[w] = 1'b0;
            last_m  = w;
            outst   = 1'b1;
            out_n   = w;
            acc_cyc = now;
          end
        end
      end
    end
    chk("rnd_all_issued", ptr[0] + ptr[1], 2 * NR);
    chk("rnd_drained", {31'd0, outst}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
